// File: rtl/ctr_sequencer_if.sv
// ctr_sequencer_if: host/counter-side signal bundle for ctr_sequencer.
//   master modport (host/bench): drives start, abort, load_value, dwell;
//                                observes control, initial_value, INIT, busy, done.
//   slave  modport (sequencer):  the mirror image of master.
//   start         request to run one schedule
//   abort         synchronous cancel
//   load_value    value to be loaded into ctr (COUNTER_SIZE bits)
//   dwell         run-phase length minus one (DWELL_WIDTH bits)
//   control       mode select to ctr
//   initial_value load value to ctr
//   INIT          load strobe to ctr
//   busy          schedule in progress
//   done          one-cycle completion pulse
interface ctr_sequencer_if #(
    parameter int COUNTER_SIZE = 3,
    parameter int DWELL_WIDTH  = 8
);
    logic                    start;
    logic                    abort;
    logic [COUNTER_SIZE-1:0] load_value;
    logic [DWELL_WIDTH-1:0]  dwell;
    logic [1:0]              control;
    logic [COUNTER_SIZE-1:0] initial_value;
    logic                    INIT;
    logic                    busy;
    logic                    done;

    modport master (
        output start, abort, load_value, dwell,
        input  control, initial_value, INIT, busy, done
    );

    modport slave (
        input  start, abort, load_value, dwell,
        output control, initial_value, INIT, busy, done
    );
endinterface

// File: rtl/ctr_sequencer.sv
// ctr_sequencer: drives the multi-mode counter ctr through a fixed
// load-then-run schedule: LOAD (INIT strobe, control=01) followed by four run
// phases with control=00,01,10,11, each lasting dwell+1 cycles.
//   clock  rising-edge clock shared with ctr
//   reset  asynchronous, active-high reset
//   bus    ctr_sequencer_if slave modport (start/abort/load_value/dwell in;
//          control/initial_value/INIT/busy/done out)
// All outputs are registered; they are computed from the next state so that
// they change on the same edge as the state itself.
module ctr_sequencer #(
    parameter int COUNTER_SIZE = 3,
    parameter int DWELL_WIDTH  = 8
) (
    input  logic           clock,
    input  logic           reset,
    ctr_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PH0,
        PH1,
        PH2,
        PH3
    } state_t;

    state_t                  state_q, state_d;
    logic [DWELL_WIDTH-1:0]  pc_q, pc_d;
    logic [COUNTER_SIZE-1:0] lv_q, lv_d;
    logic [DWELL_WIDTH-1:0]  dw_q, dw_d;

    logic [1:0]              control_q, control_d;
    logic [COUNTER_SIZE-1:0] iv_q, iv_d;
    logic                    init_q, init_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            lv_q      <= '0;
            dw_q      <= '0;
            control_q <= 2'b00;
            iv_q      <= '0;
            init_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            lv_q      <= lv_d;
            dw_q      <= dw_d;
            control_q <= control_d;
            iv_q      <= iv_d;
            init_q    <= init_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        lv_d    = lv_q;
        dw_d    = dw_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // abort has priority over a simultaneous start
                if (bus.start && !bus.abort) begin
                    lv_d    = bus.load_value;
                    dw_d    = bus.dwell;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pc_d    = '0;
                state_d = bus.abort ? IDLE : PH0;
            end
            PH0, PH1, PH2, PH3: begin
                if (bus.abort) begin
                    pc_d    = '0;
                    state_d = IDLE;
                end else if (pc_q == dw_q) begin
                    pc_d = '0;
                    case (state_q)
                        PH0:     state_d = PH1;
                        PH1:     state_d = PH2;
                        PH2:     state_d = PH3;
                        default: begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    endcase
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            default: begin
                pc_d    = '0;
                state_d = IDLE;
            end
        endcase

        // Output values for the state being entered
        control_d = 2'b00;
        init_d    = 1'b0;
        busy_d    = (state_d != IDLE);
        iv_d      = busy_d ? lv_d : '0;
        case (state_d)
            LOAD: begin
                control_d = 2'b01;
                init_d    = 1'b1;
            end
            PH1:     control_d = 2'b01;
            PH2:     control_d = 2'b10;
            PH3:     control_d = 2'b11;
            default: control_d = 2'b00;
        endcase
    end

    assign bus.control       = control_q;
    assign bus.initial_value = iv_q;
    assign bus.INIT          = init_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_ctr_sequencer.sv
// tb_ctr_sequencer: self-checking bench for ctr_sequencer. A schedule-level
// reference model (offset since start acceptance -> expected outputs) is
// compared against the DUT every cycle, plus directed length/pulse counts.
module tb_ctr_sequencer;

    logic clock;
    logic reset;

    ctr_sequencer_if #(.COUNTER_SIZE(3), .DWELL_WIDTH(8)) bus ();

    ctr_sequencer #(.COUNTER_SIZE(3), .DWELL_WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: m_t is cycles elapsed since the LOAD cycle began
    bit m_active = 0;
    bit m_done   = 0;
    int m_t      = 0;
    int m_lv     = 0;
    int m_d      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_advance(input bit r, input bit s, input bit a,
                                 input int lv, input int dw);
        if (r) begin
            m_active = 0;
            m_done   = 0;
        end else if (m_active) begin
            m_done = 0;
            if (a) begin
                m_active = 0;
            end else begin
                m_t++;
                if (m_t == 1 + 4 * (m_d + 1)) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end else begin
            m_done = 0;
            if (s && !a) begin
                m_active = 1;
                m_t      = 0;
                m_lv     = lv;
                m_d      = dw;
            end
        end
    endtask

    task automatic check_outputs();
        int ec;
        if (m_active) begin
            ec = (m_t == 0) ? 1 : (m_t - 1) / (m_d + 1);
            chk("control", 32'(bus.control), 32'(ec));
            chk("initial_value", 32'(bus.initial_value), 32'(m_lv));
            chk("INIT", 32'(bus.INIT), (m_t == 0) ? 32'd1 : 32'd0);
            chk("busy", 32'(bus.busy), 32'd1);
            chk("done", 32'(bus.done), 32'd0);
        end else begin
            chk("control", 32'(bus.control), 32'd0);
            chk("initial_value", 32'(bus.initial_value), 32'd0);
            chk("INIT", 32'(bus.INIT), 32'd0);
            chk("busy", 32'(bus.busy), 32'd0);
            chk("done", 32'(bus.done), m_done ? 32'd1 : 32'd0);
        end
    endtask

    // Called at a negedge: inputs are stable for the coming posedge
    task automatic tick();
        bit r, s, a;
        int lv, dw;
        r  = reset;
        s  = bus.start;
        a  = bus.abort;
        lv = int'(bus.load_value);
        dw = int'(bus.dwell);
        @(posedge clock);
        model_advance(r, s, a, lv, dw);
        @(negedge clock);
        check_outputs();
    endtask

    task automatic run_sched(input string tag, input int lv, input int dw, input int exp_busy);
        int nb;
        int nd;
        bus.load_value = 3'(lv);
        bus.dwell      = 8'(dw);
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        nb = bus.busy ? 1 : 0;
        nd = 0;
        for (int i = 0; i < exp_busy + 3; i++) begin
            tick();
            if (bus.busy) nb++;
            if (bus.done) nd++;
        end
        chk({tag, "_busy_len"}, 32'(nb), 32'(exp_busy));
        chk({tag, "_done_cnt"}, 32'(nd), 32'd1);
    endtask

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.load_value = '0;
        bus.dwell      = '0;

        // Reset state
        #1;
        check_outputs();
        @(negedge clock);
        reset = 1'b0;
        tick();
        tick();

        // Basic run: 1 + 4*3 = 13 busy cycles
        run_sched("basic", 3, 2, 13);

        // Minimum dwell
        run_sched("min_dwell", 5, 0, 5);

        // Abort on the 2nd PH2 cycle (dwell=4: PH2 covers offsets 11..15)
        bus.load_value = 3'd2;
        bus.dwell      = 8'd4;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        chk("abort_pre_ctl", 32'(bus.control), 32'd2);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        for (int i = 0; i < 3; i++) tick();

        // Ignored start / load_value change during PH1
        bus.load_value = 3'd3;
        bus.dwell      = 8'd2;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus.start      = 1'b1;
        bus.load_value = 3'd7;
        tick();
        bus.start = 1'b0;
        chk("ignored_iv", 32'(bus.initial_value), 32'd3);
        for (int i = 0; i < 12; i++) tick();
        chk("no_restart", 32'(bus.busy), 32'd0);

        // start + abort together in IDLE
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("start_abort_idle", 32'(bus.busy), 32'd0);
        tick();

        // Earliest restart: start held during the done cycle
        bus.load_value = 3'd4;
        bus.dwell      = 8'd0;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 20 && !bus.done; i++) tick();
        chk("restart_done_seen", 32'(bus.done), 32'd1);
        bus.start      = 1'b1;
        bus.load_value = 3'd6;
        tick();
        bus.start = 1'b0;
        chk("restart_init", 32'(bus.INIT), 32'd1);
        for (int i = 0; i < 8; i++) tick();

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            bus.start      = ($urandom_range(0, 3) == 0);
            bus.abort      = ($urandom_range(0, 19) == 0);
            bus.load_value = 3'($urandom_range(0, 7));
            bus.dwell      = 8'($urandom_range(0, 6));
            tick();
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int i = 0; i < 40; i++) tick();

        // Async reset during PH3 (dwell=3: PH3 covers offsets 13..16)
        bus.load_value = 3'd6;
        bus.dwell      = 8'd3;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("pre_reset_ctl", 32'(bus.control), 32'd3);
        #2 reset = 1'b1;
        #1;
        m_active = 0;
        m_done   = 0;
        chk("async_rst_ctl", 32'(bus.control), 32'd0);
        chk("async_rst_iv", 32'(bus.initial_value), 32'd0);
        chk("async_rst_init", 32'(bus.INIT), 32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_done", 32'(bus.done), 32'd0);
        @(negedge clock);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // Maximum dwell: 1 + 4*256 = 1025 busy cycles
        run_sched("max_dwell", 1, 255, 1025);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
